vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Source end of the VGA pixel-stream interface used by every draw_* stage in the display chain. It generates the hcount/vcount/hsync/vsync/hblnk/vblnk stream for 1024x768@60 Hz (65 MHz pclk). Its outputs feed the first overlay stage directly. All outputs are registered and mutually aligned, so any downstream stage can compare counts against sync and blank flags with no extra delay.

Parameters:
H_VISIBLE, 1024, active pixels per line
H_FP, 24, horizontal front porch in pixels
H_SYNC, 136, horizontal sync width in pixels
H_BP, 160, horizontal back porch; H_TOTAL = 1344
V_VISIBLE, 768, active lines per frame
V_FP, 3, vertical front porch in lines
V_SYNC, 6, vertical sync width in lines
V_BP, 29, vertical back porch; V_TOTAL = 806
SYNC_ACTIVE, 1, level that hsync_out/vsync_out drive during the sync window

Ports:
pclk  in  1  pixel clock, 65 MHz, all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  count enable; low freezes all outputs
hcount_out  out  11  horizontal position, 0..H_TOTAL-1
vcount_out  out  11  vertical position, 0..V_TOTAL-1
hsync_out  out  1  horizontal sync
vsync_out  out  1  vertical sync
hblnk_out  out  1  horizontal blanking
vblnk_out  out  1  vertical blanking
frame_start  out  1  one-cycle pulse marking pixel (0,0)

Behaviour:
- Reset (rst_n=0 at a pclk edge): hcount_out=0 and vcount_out=0. hsync_out and vsync_out = ~SYNC_ACTIVE. hblnk_out, vblnk_out and frame_start = 0. Reset has priority over en and takes effect mid-frame with no exceptions.
- Counting on each edge with rst_n=1 and en=1:
  - hcount_out increments by 1. At H_TOTAL-1 it wraps to 0.
  - On that wrap, vcount_out increments. At V_TOTAL-1 it wraps to 0.
  - All widths are 11-bit unsigned. No other wrap points exist.
- en=0: every output holds its value, and frame_start is forced to 0. Counting resumes from the held position when en returns high.
- Flag decode uses the next count values and is registered in the same edge as the counts. Latency from count to flag is therefore 0 cycles (aligned):
  - hblnk_out=1 iff hcount in [H_VISIBLE, H_TOTAL-1], i.e. 1024..1343.
  - hsync_out=SYNC_ACTIVE iff hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. 1048..1183.
  - vblnk_out=1 iff vcount in [768, 805].
  - vsync_out=SYNC_ACTIVE iff vcount in [771, 776].
  - vsync changes only on the cycle where hcount becomes 0.
- frame_start=1 for exactly one cycle, the cycle in which outputs show hcount=0 and vcount=0 after a wrap. It is not asserted in the reset state.
  - First pulse after reset release occurs 1344*806 = 1083264 enabled cycles later.
- State: two counters only, no FSM. Simultaneous wrap (1343,805)->(0,0) produces:
  - hblnk_out=0 and vblnk_out=0
  - hsync and vsync inactive
  - frame_start=1
- Reset deasserted while en=0: outputs stay at reset values until en=1.

Decomposition:
- Package vga_pkg holds the timing constants: H/V visible, porch, sync and total values, plus the count width (11).
- The parameter defaults come from vga_pkg.
- No sub-module. Both counters and the decode logic live in one always-block pair: sequential plus combinational next-state.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles, then release with en=1 -> during reset all outputs at reset values. First edge after release gives hcount=1, vcount=0.
- Line timing: run one line from (0,0).
  - hblnk rises at hcount=1024 and falls at 0.
  - hsync active for hcount 1048..1183 inclusive, exactly 136 cycles.
  - vcount steps to 1 when hcount returns to 0.
- Frame timing: run 2 full frames.
  - vblnk high for vcount 768..805.
  - vsync active for vcount 771..776, exactly 6*1344 = 8064 cycles.
  - frame_start pulses exactly twice, 1083264 cycles apart, each coinciding with (0,0).
- Enable stall: deassert en for 10 cycles at hcount=1100 (inside hsync) -> all outputs frozen and frame_start 0. After re-enable, hsync deasserts at hcount=1184 with total active width still 136 enabled cycles.
- Mid-frame reset: assert rst_n=0 at (500,400) -> next edge gives hcount=0, vcount=0, all flags inactive. Recount proceeds normally, and no frame_start occurs until a full frame has elapsed.
- Corner wrap: observe the transition from (1343,805) -> (0,0) in one cycle, with hblnk and vblnk falling together and frame_start=1 for that single cycle only.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA 1024x768@60 timing constants shared by the display chain.
package vga_pkg;

  localparam int CW = 11;

  localparam int VGA_H_VISIBLE = 1024;
  localparam int VGA_H_FP      = 24;
  localparam int VGA_H_SYNC    = 136;
  localparam int VGA_H_BP      = 160;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP
                               + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 768;
  localparam int VGA_V_FP      = 3;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_BP      = 29;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP
                               + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_SYNC_ACTIVE = 1'b1;

endpackage

// File: rtl/vga_timing_gen.sv
// Source of the VGA pixel stream: counters plus registered,
// count-aligned sync/blank flags and a frame-start pulse.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] hcount_out,
  output logic [CW-1:0] vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          hblnk_out,
  output logic          vblnk_out,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_BLK  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SS   = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_BLK  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SS   = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          hb_nxt;
  logic          vb_nxt;
  logic          fs_nxt;

  // Flags decode the next counts so they land on the same edge.
  always_comb begin
    h_nxt = hcount_out + CW'(1);
    v_nxt = vcount_out;
    if (hcount_out == H_LAST) begin
      h_nxt = '0;
      if (vcount_out == V_LAST) v_nxt = '0;
      else                      v_nxt = vcount_out + CW'(1);
    end
    hb_nxt = (h_nxt >= H_BLK);
    vb_nxt = (v_nxt >= V_BLK);
    hs_nxt = ((h_nxt >= H_SS) && (h_nxt <= H_SE)) ?
             SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nxt = ((v_nxt >= V_SS) && (v_nxt <= V_SE)) ?
             SYNC_ACTIVE : ~SYNC_ACTIVE;
    fs_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= ~SYNC_ACTIVE;
      vsync_out   <= ~SYNC_ACTIVE;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount_out  <= h_nxt;
      vcount_out  <= v_nxt;
      hsync_out   <= hs_nxt;
      vsync_out   <= vs_nxt;
      hblnk_out   <= hb_nxt;
      vblnk_out   <= vb_nxt;
      frame_start <= fs_nxt;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scaled-timing instance with a model
// scoreboard, plus a full 1024x768 instance for real line timing.
module tb_vga_timing_gen;

  localparam int HV = 16, HFP = 4, HS = 6, HBP = 6;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VV = 12, VFP = 2, VS = 3, VBP = 3;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam logic SA = 1'b1;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [10:0] hcount, vcount;
  logic hsync, vsync, hblnk, vblnk, frame_start;

  logic rst_nf = 1'b0;
  logic enf = 1'b0;
  logic [10:0] hf, vf;
  logic hsf, vsf, hbf, vbf, fsf;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACTIVE(SA)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount_out(hcount), .vcount_out(vcount),
    .hsync_out(hsync), .vsync_out(vsync),
    .hblnk_out(hblnk), .vblnk_out(vblnk),
    .frame_start(frame_start)
  );

  vga_timing_gen dut_full (
    .pclk(pclk), .rst_n(rst_nf), .en(enf),
    .hcount_out(hf), .vcount_out(vf),
    .hsync_out(hsf), .vsync_out(vsf),
    .hblnk_out(hbf), .vblnk_out(vbf),
    .frame_start(fsf)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, hb, vb, fs;
  } exp_t;

  exp_t sb[$];
  int mh = 0, mv = 0;
  logic mfs = 1'b0;
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out(int h, int v, logic fs);
    exp_t e;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hb = (h >= HV);
    e.vb = (v >= VV);
    e.hs = (h >= HV + HFP && h <= HV + HFP + HS - 1) ? SA : ~SA;
    e.vs = (v >= VV + VFP && v <= VV + VFP + VS - 1) ? SA : ~SA;
    e.fs = fs;
    return e;
  endfunction

  task automatic step(input logic r, input logic e);
    exp_t x;
    @(negedge pclk);
    rst_n = r;
    en = e;
    if (!r) begin
      mh = 0; mv = 0; mfs = 1'b0;
    end else if (e) begin
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
      mfs = (mh == 0 && mv == 0);
    end else begin
      mfs = 1'b0;
    end
    sb.push_back(model_out(mh, mv, mfs));
    @(posedge pclk);
    #1;
    x = sb.pop_front();
    chk("hcount", hcount, x.h);
    chk("vcount", vcount, x.v);
    chk("hsync", hsync, x.hs);
    chk("vsync", vsync, x.vs);
    chk("hblnk", hblnk, x.hb);
    chk("vblnk", vblnk, x.vb);
    chk("frame_start", frame_start, x.fs);
  endtask

  initial begin
    int i, n, cnt, found, last;
    int hb_rise, hs_n, vs_n, vb_n, fs_n, hs_first, hs_last, hb_n;
    logic [10:0] ph, pv;
    logic phb, pvb;

    // reset held, then release
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("first_h", hcount, 1);
    chk("first_v", vcount, 0);

    // one line
    hb_rise = -1; hs_n = 0; i = 0;
    while (hcount != 0 && i < 2 * HT) begin
      step(1'b1, 1'b1);
      i++;
      if (hblnk && hb_rise < 0) hb_rise = hcount;
      if (hsync === SA) hs_n++;
    end
    chk("line_end_h", hcount, 0);
    chk("line_vstep", vcount, 1);
    chk("hblnk_rise", hb_rise, HV);
    chk("hsync_width", hs_n, HS);
    chk("hblnk_fall", hblnk, 0);

    // two frames
    found = 0;
    for (int k = 0; k < 2 * FT && found == 0; k++) begin
      step(1'b1, 1'b1);
      if (frame_start) found = 1;
    end
    chk("fs_found", found, 1);
    fs_n = 0; vs_n = 0; vb_n = 0; last = 0;
    for (int k = 1; k <= 2 * FT; k++) begin
      ph = hcount; pv = vcount; phb = hblnk; pvb = vblnk;
      step(1'b1, 1'b1);
      if (vsync === SA) vs_n++;
      if (vblnk) vb_n++;
      if (frame_start) begin
        fs_n++;
        chk("fs_gap", k - last, FT);
        last = k;
        chk("wrap_prev_h", ph, HT - 1);
        chk("wrap_prev_v", pv, VT - 1);
        chk("wrap_prev_blk", {phb, pvb}, 2'b11);
        chk("wrap_blk", {hblnk, vblnk}, 2'b00);
      end
    end
    chk("fs_pulses", fs_n, 2);
    chk("vsync_cycles", vs_n, 2 * VS * HT);
    chk("vblnk_cycles", vb_n, 2 * (VT - VV) * HT);

    // stall inside hsync
    i = 0;
    while (hcount != HV + HFP && i < 2 * HT) begin
      step(1'b1, 1'b1);
      i++;
    end
    chk("hs_start_reach", hcount, HV + HFP);
    cnt = (hsync === SA) ? 1 : 0;
    while (hcount != HV + HFP + 2 && i < 4 * HT) begin
      step(1'b1, 1'b1);
      i++;
      if (hsync === SA) cnt++;
    end
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    chk("stall_hold_h", hcount, HV + HFP + 2);
    i = 0;
    while (hsync === SA && i < 2 * HT) begin
      step(1'b1, 1'b1);
      i++;
      if (hsync === SA) cnt++;
    end
    chk("hs_end_h", hcount, HV + HFP + HS);
    chk("hs_width_stall", cnt, HS);

    // mid-frame reset
    i = 0;
    while (!(hcount == 10 && vcount == 8) && i < 2 * FT) begin
      step(1'b1, 1'b1);
      i++;
    end
    chk("mid_reach", (hcount == 10 && vcount == 8), 1);
    step(1'b0, 1'b1);
    chk("mid_rst_h", hcount, 0);
    chk("mid_rst_v", vcount, 0);
    chk("mid_rst_flags", {hsync, vsync, hblnk, vblnk, frame_start},
        {~SA, ~SA, 3'b000});
    step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    chk("rst_en0_hold", hcount, 0);
    n = 0; found = 0;
    for (int k = 0; k < 2 * FT && found == 0; k++) begin
      step(1'b1, 1'b1);
      n++;
      if (frame_start) found = 1;
    end
    chk("recount_fs", found, 1);
    chk("recount_len", n, FT);

    // full-size line timing
    @(negedge pclk);
    rst_nf = 1'b0;
    enf = 1'b1;
    @(posedge pclk);
    #1;
    chk("full_rst_h", hf, 0);
    chk("full_rst_flags", {hsf, vsf, hbf, vbf, fsf}, {~SA, ~SA, 3'b000});
    @(negedge pclk);
    rst_nf = 1'b1;
    hb_rise = -1; hs_first = -1; hs_last = -1; hs_n = 0; hb_n = 0;
    for (int k = 0; k < 1344; k++) begin
      @(posedge pclk);
      #1;
      if (k == 0) chk("full_first_h", hf, 1);
      if (hbf) begin
        hb_n++;
        if (hb_rise < 0) hb_rise = hf;
      end
      if (hsf === SA) begin
        hs_n++;
        if (hs_first < 0) hs_first = hf;
        hs_last = hf;
      end
    end
    chk("full_hblnk_rise", hb_rise, 1024);
    chk("full_hblnk_cnt", hb_n, 320);
    chk("full_hs_first", hs_first, 1048);
    chk("full_hs_last", hs_last, 1183);
    chk("full_hs_cnt", hs_n, 136);
    chk("full_end_h", hf, 0);
    chk("full_end_v", vf, 1);
    chk("full_end_hb", hbf, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
